// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e : controller FSM states (IDLE, REQ, WAIT)
//   fetch_entry_t : one buffered instruction together with the PC it was fetched from
//   INSTR_BYTES   : PC increment between sequential fetches
//   align_word()  : clears the byte-offset bits of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Instruction buffer: a small FIFO of fetch_entry_t with a zero-latency head.
// Ports:
//   clk_i, rst_ni  : clock (rising edge), asynchronous active-low reset
//   push_i         : write push_data_i at the tail
//   push_data_i    : entry to write
//   pop_i          : drop the head entry (ignored when empty)
//   flush_i        : empty the buffer; wins over push and pop in the same cycle
//   count_o        : number of valid entries
//   head_o         : oldest entry, valid only while empty_o is low
//   empty_o        : no valid entries
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  fetch_entry_t                 push_data_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output fetch_entry_t                 head_o,
  output logic                         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count_q
  // alone, and the top masks the head while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  // The controller only requests when a slot is reserved, so a push can
  // never land on a full buffer.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(do_push && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Owns the fetch PC, issues one word request at a
// time over a req/gnt/rvalid memory port, buffers returned instructions and
// hands {instr, pc} pairs to decode. Redirects flush the buffer and cause any
// response already in flight to be dropped.
// Ports:
//   clk_i, rst_ni            : clock (rising edge), asynchronous active-low reset
//   en_i                     : fetch enable; low blocks new requests
//   imem_req_o/imem_addr_o   : request and word address (always the fetch PC)
//   imem_gnt_i               : request accepted this cycle
//   imem_rvalid_i/imem_rdata_i : read response
//   redirect_i/redirect_pc_i : redirect pulse and target
//   instr_valid_o/instr_o/instr_pc_o/instr_ready_i : decode handshake
//   busy_o                   : request pending or response outstanding
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic        busy_o
);

  localparam int            CW      = $clog2(BUF_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(BUF_DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fpc_q, fpc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         discard_q, discard_d;

  logic [CW-1:0] buf_count;
  logic [CW:0]   occupancy;
  logic          outstanding;
  logic          slot_free;
  logic          buf_push;
  logic          buf_pop;
  logic          buf_empty;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // A slot is reserved for the response in flight, so a new request is only
  // allowed while buffered entries plus the outstanding one leave room.
  assign outstanding = (state_q == WAIT);
  assign occupancy   = {1'b0, buf_count} + {{CW{1'b0}}, outstanding};
  assign slot_free   = (occupancy < DEPTH_W);

  // A response is kept only when it is not marked stale and no redirect
  // arrives alongside it.
  assign buf_push   = (state_q == WAIT) && imem_rvalid_i && !discard_q && !redirect_i;
  assign buf_pop    = instr_valid_o && instr_ready_i;
  assign push_entry = '{instr: imem_rdata_i, pc: req_pc_q};

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d   = state_q;
    fpc_d     = fpc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;

    unique case (state_q)
      IDLE: begin
        if (en_i && slot_free) state_d = REQ;
      end
      REQ: begin
        // Address is fpc_q and stays put until granted.
        if (imem_gnt_i) begin
          req_pc_d = fpc_q;
          fpc_d    = fpc_q + INSTR_BYTES;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = (en_i && slot_free) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides the normal sequencing in every state.
    if (redirect_i) begin
      fpc_d = align_word(redirect_pc_i);
      unique case (state_q)
        REQ: begin
          // Granted now: the response is still coming and must be dropped.
          // Not granted: withdraw and reissue at the target from IDLE.
          state_d   = imem_gnt_i ? WAIT : IDLE;
          discard_d = imem_gnt_i;
        end
        WAIT: begin
          // Response arriving now is dropped directly; otherwise mark it stale.
          state_d   = imem_rvalid_i ? IDLE : WAIT;
          discard_d = !imem_rvalid_i;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      fpc_q     <= RESET_PC;
      req_pc_q  <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
    end
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (buf_push),
    .push_data_i (push_entry),
    .pop_i       (buf_pop),
    .flush_i     (redirect_i),
    .count_o     (buf_count),
    .head_o      (head),
    .empty_o     (buf_empty)
  );

  assign imem_req_o    = (state_q == REQ);
  assign imem_addr_o   = fpc_q;
  assign instr_valid_o = !buf_empty;
  // Head storage is unreset, so force zeros while nothing is valid.
  assign instr_o       = buf_empty ? '0 : head.instr;
  assign instr_pc_o    = buf_empty ? '0 : head.pc;
  assign busy_o        = (state_q != IDLE) || discard_q;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch path: owns the fetch PC, issues word requests over a req/gnt/rvalid instruction-memory interface, and buffers returned instructions for decode.
- Applies redirects (branch, JAL, JALR targets computed downstream) with flushing of stale data.
- Sits between the PC/next-PC logic and instruction memory; decode consumes {instr, pc} pairs through a valid/ready handshake.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- BUF_DEPTH, 2, instruction buffer entries; legal values are 2 and 4.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  fetch enable; low blocks new requests.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  32  request word address; always equals fetch PC.
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- redirect_i  in  1  redirect pulse from branch/jump resolution.
- redirect_pc_i  in  32  redirect target.
- instr_valid_o  out  1  buffer head valid.
- instr_o  out  32  head instruction.
- instr_pc_o  out  32  head PC.
- instr_ready_i  in  1  decode accepts head.
- busy_o  out  1  request pending or response outstanding.

Behaviour:
- Reset (async assert, sync release):
  - fpc = RESET_PC; state = IDLE; buffer empty.
  - discard = 0; imem_req_o = 0; instr_valid_o = 0; busy_o = 0.
  - instr_o and instr_pc_o = 0.
- At most one outstanding request. Slots free = BUF_DEPTH - count - outstanding.
- FSM states:
  - IDLE: go to REQ when en_i = 1, slots free > 0, and no redirect this cycle.
  - REQ: imem_req_o = 1. On imem_gnt_i: fpc <= fpc + 4, record the request PC, go to WAIT. Address holds stable while waiting for grant.
  - WAIT: on imem_rvalid_i, either push {imem_rdata_i, req_pc} or drop it if discard = 1 (discard then clears). Then go to REQ if en_i = 1 and slots free > 0, otherwise IDLE. Back-to-back fetch is one request per 2 cycles minimum.
- Redirect, highest priority:
  - Always: fpc <= {redirect_pc_i[31:2], 2'b00}, buffer flushed, instr_valid_o = 0 next cycle.
  - In REQ without grant: request withdrawn, state goes to IDLE for one cycle, and the request reissues at the new PC.
  - In REQ with grant the same cycle: the granted response is discarded (discard = 1, go to WAIT); fpc takes the redirect target, not +4.
  - In WAIT with rvalid the same cycle: the response is dropped.
  - In WAIT without rvalid: discard = 1.
  - Redirect during an active discard keeps discard = 1. A response is never pushed after a redirect that was issued before it.
- Buffer:
  - FIFO; head is driven directly (zero-latency) onto instr_o and instr_pc_o.
  - Pop when instr_valid_o and instr_ready_i.
  - Push and pop in the same cycle are allowed; count is unchanged.
  - Overflow is impossible by the slot rule; a push while full is an assertion failure.
  - Pop while empty: no effect.
- en_i low mid-operation: the outstanding response still completes and is buffered; no new request is issued.
- Arithmetic: fpc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- busy_o = (state != IDLE) or discard.

Decomposition:
- fetch_pkg holds:
  - fetch_state_e {IDLE, REQ, WAIT}.
  - fetch_entry_t {logic [31:0] instr; logic [31:0] pc}.
  - Constant INSTR_BYTES = 4.
- One sub-module, fetch_buf: a parameterized FIFO of fetch_entry_t with push, pop, flush, count, and head ports.
- The controller FSM, fpc, and discard logic stay in fetch_ctrl.

Test Plan:
- Reset, en_i = 1, gnt same cycle, rvalid one cycle later, ready = 1 -> instr_pc_o sequence 0x0, 0x4, 0x8; first instr_valid_o on cycle 3 after reset release.
- instr_ready_i = 0 with BUF_DEPTH = 2 -> exactly 2 entries buffered (PC 0x0, 0x4), imem_req_o stays 0; one pop -> one new request at 0x8.
- Redirect to 0x1003 while in WAIT at PC 0x8 -> the rvalid for 0x8 is dropped, next request addr 0x1000, next delivered instr_pc_o = 0x1000.
- Redirect to 0x200 in the same cycle as gnt for 0x10 -> the 0x10 response is discarded, next request addr 0x200, no 0x14 request.
- Redirect while head valid and ready = 1 -> instr_valid_o = 0 the following cycle and the buffer is empty.
- RESET_PC = 32'hFFFF_FFFC; also rst_ni asserted mid-WAIT -> PC wraps to 0x0 after 0xFFFF_FFFC; outputs clear immediately and the late rvalid after reset is ignored.
